// File: rtl/fa_serial_adder_ctrl_pkg.sv
// Shared encodings for the bit-serial add/subtract controller.
// Both the FSM state values and the add/sub opcode live here.
package fa_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_serial_adder_ctrl_fa.sv
// Full-adder cell built only from two-input NAND gates.
// This single cell is time-shared across every bit of the serial adder.
module FA_Universal_Structural (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic n1, n2, n3, axb, n4, n5, n6;

    // Two NAND-based XOR stages give the sum; the carry reuses n1 and n4.
    assign n1   = ~(a & b);
    assign n2   = ~(a & n1);
    assign n3   = ~(b & n1);
    assign axb  = ~(n2 & n3);
    assign n4   = ~(axb & cin);
    assign n5   = ~(axb & n4);
    assign n6   = ~(cin & n4);
    assign sum  = ~(n5 & n6);
    assign cout = ~(n1 & n4);

endmodule

// File: rtl/fa_serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell processes one bit per clock,
// LSB first, between a valid/ready requester and a valid/ready consumer.
module fa_serial_adder_ctrl
    import fa_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              carry_q;
    logic [CW-1:0]     cnt;
    logic              fa_sum;
    logic              fa_cout;
    logic [WIDTH-1:0]  sum_next;

    FA_Universal_Structural u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    always_comb begin
        sum_next            = sum >> 1;
        sum_next[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                        a_sh     <= a;
                        b_sh     <= (sub == OP_SUB) ? ~b : b;
                        carry_q  <= (sub == OP_SUB);
                        cnt      <= '0;
                        sum      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum     <= sum_next;
                    carry_q <= fa_cout;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        overflow  <= carry_q ^ fa_cout;
                        cout      <= fa_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_serial_adder_ctrl.sv
// Self-checking bench for fa_serial_adder_ctrl at WIDTH=8: directed cases followed by
// randomized operations compared against an arithmetic reference model.
module tb_fa_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    fa_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference result from plain integer arithmetic: {overflow, cout, sum}.
    function automatic logic [9:0] refModel(input logic [7:0] opA, input logic [7:0] opB, input logic opSub);
        int ua, ub, ur, sa, sb, sr;
        logic [7:0] rs;
        logic rc, ro;
        ua = int'(opA);
        ub = int'(opB);
        sa = int'($signed(opA));
        sb = int'($signed(opB));
        ur = opSub ? (ua - ub) : (ua + ub);
        sr = opSub ? (sa - sb) : (sa + sb);
        rs = 8'(ur & 255);
        rc = opSub ? (ua >= ub) : (ur > 255);
        ro = (sr > 127) || (sr < -128);
        return {ro, rc, rs};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // noise: 0 quiet, 1 one start pulse with a=0x11 mid-run, 2 random start/out_ready during run.
    task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input logic opSub,
                                 input int holdCycles, input int noise, output int acceptCycle);
        logic [9:0] expv;
        logic [7:0] heldSum;
        logic       heldCout;
        int         lat;
        expv = refModel(opA, opB, opSub);
        checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
        a     = opA;
        b     = opB;
        sub   = opSub;
        start = 1'b1;
        step();
        acceptCycle = cycle;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        sub   = 1'($urandom);
        checkOutput("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noise == 1) begin
                start = (lat == 2);
                a     = 8'h11;
            end else if (noise == 2) begin
                start     = 1'($urandom);
                out_ready = 1'($urandom);
            end
            step();
            lat++;
        end
        start = 1'b0;
        checkOutput("latency", 32'(lat), 32'd8);
        if (!out_valid) return;
        checkOutput("sum", 32'(sum), 32'(expv[7:0]));
        checkOutput("cout", 32'(cout), 32'(expv[8]));
        checkOutput("overflow", 32'(overflow), 32'(expv[9]));
        checkOutput("in_ready_done", 32'(in_ready), 32'd0);
        heldSum  = sum;
        heldCout = cout;
        for (int i = 0; i < holdCycles; i++) begin
            out_ready = 1'b0;
            step();
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_sum", 32'(sum), 32'(heldSum));
            checkOutput("hold_cout", 32'(cout), 32'(heldCout));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("out_valid_after_handshake", 32'(out_valid), 32'd0);
        checkOutput("in_ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t1, t2, tDummy;
        logic [7:0] ra, rb;
        logic       rsub;
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        $display("[TB] starting fa_serial_adder_ctrl bench");
        repeat (3) step();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        step();

        applyStimulus(8'h3C, 8'h5A, 1'b0, 0, 0, tDummy);
        applyStimulus(8'hFF, 8'h01, 1'b0, 0, 0, tDummy);
        applyStimulus(8'h05, 8'h07, 1'b1, 0, 0, tDummy);
        applyStimulus(8'h80, 8'h01, 1'b1, 5, 1, tDummy);

        // Abort in the third RUN cycle; nothing from the partial op may appear.
        a     = 8'hAA;
        b     = 8'h55;
        sub   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        repeat (10) step();
        checkOutput("abort_stays_idle", 32'(out_valid), 32'd0);

        applyStimulus(8'h01, 8'h02, 1'b0, 0, 0, t1);
        applyStimulus(8'h10, 8'h20, 1'b1, 0, 0, t2);
        checkOutput("issue_interval", 32'(t2 - t1), 32'(WIDTH + 2));

        for (int n = 0; n < 25; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rsub = 1'($urandom);
            applyStimulus(ra, rb, rsub, int'($urandom_range(0, 3)), 2, tDummy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
